seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus carry-in by processing CHUNK bits per clock cycle, rippling the carry between chunks through a register. It generalises the team's two-bit combinational ripple adder to arbitrary width, with a start/busy/done handshake. It sits between operand registers and any consumer that can tolerate WIDTH/CHUNK cycles of latency in exchange for a short carry chain.

## Interface
- WIDTH, 8: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 2: bits added per cycle; must satisfy 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when s/cout are updated.
- s  output  WIDTH  registered sum; holds its value until the next completion.
- cout  output  1  registered carry-out; holds its value until the next completion.
- ovf  output  1  signed overflow; present only with ADDER_OVF_EN.

## Operation
- NCHUNK = WIDTH/CHUNK. The chunk index counter is $clog2(NCHUNK)+1 bits wide.
- States:
  - IDLE: start=1 latches a, b and cin into working registers; carry register = cin; idx = 0; go to RUN.
  - RUN: each cycle, the CHUNK-bit sum of a_w[idx], b_w[idx] and carry is written to work_s[idx].
    - Chunk carry-out goes to the carry register; idx increments.
    - On the edge that processes idx = NCHUNK-1: s ← final work_s, cout ← final carry, go to DONE.
  - DONE: lasts one cycle.
    - start=1: accept new operands exactly as in IDLE and go to RUN.
    - start=0: go to IDLE.
- start in RUN is ignored. Operands are not re-sampled, and a/b/cin changes during RUN have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- s and cout change only on a completion edge. Values between completions are stable.
- If WIDTH % CHUNK ≠ 0 or CHUNK > WIDTH, elaboration fails via $error in an initial/generate check.

## Timing
- Reset (rst_n=0 at a rising edge) sets state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, idx=0, and clears the working registers.
- Reset mid-RUN aborts the operation. No done pulse is produced and s is cleared.
- Start accepted at edge E0:
  - busy=1 from after E0 to after E(NCHUNK).
  - s/cout/done update at edge E(NCHUNK); done=1 for the following cycle only.
  - Latency is NCHUNK cycles.
- CHUNK = WIDTH gives a latency of 1 cycle.
- Back-to-back: start held high during DONE gives a new acceptance at edge E(NCHUNK+1). Throughput is one result per NCHUNK+1 cycles.
- busy and done are never high in the same cycle.

## Configuration
- ADDER_OVF_EN defined:
  - Output ovf exists.
  - ovf = (carry into bit WIDTH-1) XOR cout, registered and updated with s.
  - Reset value is 0.
- ADDER_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package adder_pkg:
  - state_t enum {IDLE, RUN, DONE} as 2-bit logic.
  - Helper function nchunk(width, chunk).
- Sub-module ripple_adder_n #(N):
  - Combinational N-bit ripple adder built from full-adder bit cells.
  - Outputs: sum[N-1:0], cout, and c_msb (carry into bit N-1) for overflow.
  - Instantiated once with N=CHUNK.

## Test plan
Use WIDTH=8, CHUNK=2 throughout.
- Reset: rst_n=0 for 2 cycles with start=1 → busy=0, done=0, s=8'h00, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0, start pulse at E0 → done high only in the cycle after E4; s=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 → s=8'h80, cout=0, ovf=1.
- a=8'h0F, b=8'hF0, cin=1 → s=8'h00, cout=1.
- Start ignored during RUN: at E2, change to a=8'h01, b=8'h01 with start=1 → the first result is still s=8'h00, cout=1 at E4.
- Start held high through DONE → a second acceptance at E5 and a second done after E9.
- Reset mid-run: rst_n=0 at E2 → no done pulse; s=0; busy=0 in the next cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunk-wide slices in a word; guarded against a zero chunk so
    // the parameter check in the top can report the problem cleanly.
    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// Combinational N-bit ripple adder built from full-adder bit cells.
// c_msb is the carry into bit N-1, used for signed overflow detection.
module ripple_adder_n #(
    parameter int N = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout  = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: adds a + b + cin CHUNK bits per clock, carrying between
// chunks through a register, with a start/busy/done handshake.
// Optional feature macro: ADDER_OVF_EN adds a registered signed-overflow
// output (ovf) updated together with s/cout.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = $clog2(NCHUNK) + 1;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_w_q, a_w_d;
    logic [WIDTH-1:0]   b_w_q, b_w_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   work_s_q, work_s_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
`ifdef ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_sum;
    logic               chunk_cout, chunk_cmsb;

    // Select the operand slices addressed by the current chunk index.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_w_q[i*CHUNK +: CHUNK];
                chunk_b = b_w_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_adder_n #(
        .N (CHUNK)
    ) u_chunk_add (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

`ifndef ADDER_OVF_EN
    // Carry into the MSB only matters when overflow reporting is built in.
    logic unused_cmsb;
    assign unused_cmsb = chunk_cmsb;
`endif

    // Next-state and datapath update: load on accepted start, one chunk per RUN cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_w_d    = a_w_q;
        b_w_d    = b_w_q;
        carry_d  = carry_q;
        work_s_d = work_s_q;
        s_d      = s_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
`ifdef ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_w_d    = a;
                    b_w_d    = b;
                    carry_d  = cin;
                    idx_d    = '0;
                    work_s_d = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        work_s_d[i*CHUNK +: CHUNK] = chunk_sum;
                    end
                end
                carry_d = chunk_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    s_d     = work_s_d;
                    cout_d  = chunk_cout;
`ifdef ADDER_OVF_EN
                    ovf_d   = chunk_cmsb ^ chunk_cout;
`endif
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_w_q    <= '0;
            b_w_q    <= '0;
            carry_q  <= 1'b0;
            work_s_q <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_w_q    <= a_w_d;
            b_w_q    <= b_w_d;
            carry_q  <= carry_d;
            work_s_q <= work_s_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
`ifdef ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
`ifdef ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (WIDTH=8, CHUNK=2). Covers ovf when
// ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b, s;
    logic             cin, busy, done, cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        int               acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain wide arithmetic; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mc, input int acc);
        exp_t e;
        int   total;
        total  = int'(ma) + int'(mb) + int'(mc);
        e.s    = total[WIDTH-1:0];
        e.cout = total[WIDTH];
        e.ovf  = (ma[WIDTH-1] == mb[WIDTH-1]) && (e.s[WIDTH-1] != ma[WIDTH-1]);
        e.a    = ma;
        e.b    = mb;
        e.cin  = mc;
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: pop and compare on every done; check exclusivity and output stability.
    logic [WIDTH-1:0] last_s;
    logic             last_cout;
    logic             prev_rst = 1'b0;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            check("busy_done_excl", 32'(busy & done), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sum", 32'(s), 32'(mon_e.s));
                    check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef ADDER_OVF_EN
                    check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
                    check("latency", 32'(cyc - mon_e.acc), 32'(NCHUNK));
                    $display("txn a=%02h b=%02h cin=%0d -> s=%02h cout=%0d (exp s=%02h cout=%0d) latency=%0d",
                             mon_e.a, mon_e.b, mon_e.cin, s, cout, mon_e.s, mon_e.cout, cyc - mon_e.acc);
                end
            end else begin
                check("s_stable", 32'(s), 32'(last_s));
                check("cout_stable", 32'(cout), 32'(last_cout));
            end
        end
        last_s    = s;
        last_cout = cout;
        prev_rst  = rst_n;
    end

    // Issue one operation starting at the current negedge; returns at the DONE-cycle negedge.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input int gap);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        exp_q.push_back(model(ia, ib, ic, cyc));
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        check("busy_run", 32'(busy), 32'd1);
        repeat (NCHUNK) @(negedge clk);
        check("busy_in_done", 32'(busy), 32'd0);
        repeat (gap) @(negedge clk);
    endtask

    logic [WIDTH-1:0] dir_a [6] = '{8'hFF, 8'h7F, 8'h0F, 8'h00, 8'h80, 8'hFF};
    logic [WIDTH-1:0] dir_b [6] = '{8'h01, 8'h01, 8'hF0, 8'h00, 8'h80, 8'hFF};
    logic             dir_c [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset with start asserted.
        rst_n = 1'b0; start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);

        // Directed operand patterns, each followed by one idle cycle.
        for (int i = 0; i < 6; i++) issue(dir_a[i], dir_b[i], dir_c[i], 1);

        // Start and operand changes during RUN are ignored.
        a = 8'h0F; b = 8'hF0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        exp_q.push_back(model(8'h0F, 8'hF0, 1'b1, cyc));
        start = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start held high through DONE: second acceptance one cycle after completion.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        exp_q.push_back(model(8'h12, 8'h34, 1'b0, cyc));
        a = 8'hA5; b = 8'h5A; cin = 1'b1;
        repeat (NCHUNK + 1) @(negedge clk);
        exp_q.push_back(model(8'hA5, 8'h5A, 1'b1, cyc));
        check("busy_b2b", 32'(busy), 32'd1);
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (NCHUNK + 1) @(negedge clk);

        // Reset mid-run aborts without a done pulse.
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Randomized operations, gap 0 gives back-to-back acceptance.
        for (int i = 0; i < 40; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
